// File: rtl/fcmp_pkg.sv
// Shared definitions for the pipelined floating-point compare unit:
// operation encodings and the canonical quiet-NaN pattern.
package fcmp_pkg;

  localparam int FCMP_OP_W  = 3;
  localparam int FCMP_MAX_W = 128;

  typedef enum logic [FCMP_OP_W-1:0] {
    FCMP_LT  = 3'b000,
    FCMP_LE  = 3'b001,
    FCMP_EQ  = 3'b010,
    FCMP_MIN = 3'b011,
    FCMP_MAX = 3'b100
  } fcmp_op_t;

  // {sign 0, exponent all ones, fraction MSB set, rest zero}; callers truncate to their width
  function automatic logic [FCMP_MAX_W-1:0] fcmp_canon_nan(input int exp_w, input int man_w);
    logic [FCMP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fcmp_class.sv
// Combinational operand classification and sign-magnitude ordering.
// NaN detection is present only when FCMP_NAN_EN is defined.
module fcmp_class
  import fcmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 lt,
  output logic                 eq,
  output logic                 nan_a,
  output logic                 nan_b
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic           sa, sb;
  logic [W-2:0]   ma, mb;
  logic           zero_a, zero_b;

  assign sa     = a[W-1];
  assign sb     = b[W-1];
  assign ma     = a[W-2:0];
  assign mb     = b[W-2:0];
  assign zero_a = (a[W-2:MAN_W] == '0) && (a[MAN_W-1:0] == '0);
  assign zero_b = (b[W-2:MAN_W] == '0) && (b[MAN_W-1:0] == '0);

  // Exponent and fraction concatenated order identically to the value magnitude
  always_comb begin
    lt = 1'b0;
    eq = 1'b0;
    if (zero_a && zero_b) begin
      eq = 1'b1;
    end else if (sa != sb) begin
      lt = sa;
    end else if (!sa) begin
      lt = (ma < mb);
      eq = (ma == mb);
    end else begin
      lt = (ma > mb);
      eq = (ma == mb);
    end
  end

`ifdef FCMP_NAN_EN
  assign nan_a = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
  assign nan_b = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
`else
  assign nan_a = 1'b0;
  assign nan_b = 1'b0;
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage valid/ready floating-point compare (LT/LE/EQ/MIN/MAX).
// NaN handling is enabled by defining FCMP_NAN_EN; otherwise every pattern is ordered.
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FCMP_OP_W-1:0] in_op,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_inv
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON_NAN = W'(fcmp_canon_nan(EXP_W, MAN_W));

  logic                 vld_p1, vld_p2;
  logic [FCMP_OP_W-1:0] op_p1;
  logic [W-1:0]         a_p1, b_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic                 lt_p1, eq_p1, nan_a_p1, nan_b_p1;
  logic [W-1:0]         data_p2;
  logic [TAG_W-1:0]     tag_p2;
  logic                 inv_p2;

  logic                 lt_c, eq_c, nan_a_c, nan_b_c;
  logic                 s2_free, s1_advance, accept;
  logic                 any_nan;
  logic [W-1:0]         res_data;
  logic                 res_inv;

  assign s2_free    = !vld_p2 || out_ready;
  assign s1_advance = vld_p1 && s2_free;
  assign in_ready   = !vld_p1 || s1_advance;
  assign accept     = in_valid && in_ready;

  // Stage 1: classify and order the operands
  fcmp_class #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_class (
    .a     (in_a),
    .b     (in_b),
    .lt    (lt_c),
    .eq    (eq_c),
    .nan_a (nan_a_c),
    .nan_b (nan_b_c)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1    <= in_op;
      a_p1     <= in_a;
      b_p1     <= in_b;
      tag_p1   <= in_tag;
      lt_p1    <= lt_c;
      eq_p1    <= eq_c;
      nan_a_p1 <= nan_a_c;
      nan_b_p1 <= nan_b_c;
    end
  end

  // Stage 2: op select; MIN favours a and MAX favours b on equality
  always_comb begin
    any_nan  = nan_a_p1 || nan_b_p1;
    res_data = '0;
    res_inv  = any_nan;
    case (op_p1)
      FCMP_LT: res_data[0] = lt_p1 && !any_nan;
      FCMP_LE: res_data[0] = (lt_p1 || eq_p1) && !any_nan;
      FCMP_EQ: res_data[0] = eq_p1 && !any_nan;
      FCMP_MIN: begin
        if (nan_a_p1 && nan_b_p1) res_data = CANON_NAN;
        else if (nan_a_p1)        res_data = b_p1;
        else if (nan_b_p1)        res_data = a_p1;
        else                      res_data = (lt_p1 || eq_p1) ? a_p1 : b_p1;
      end
      FCMP_MAX: begin
        if (nan_a_p1 && nan_b_p1) res_data = CANON_NAN;
        else if (nan_a_p1)        res_data = b_p1;
        else if (nan_b_p1)        res_data = a_p1;
        else                      res_data = (lt_p1 || eq_p1) ? b_p1 : a_p1;
      end
      default: begin
        res_data = '0;
        res_inv  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
      inv_p2  <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (s2_free)  vld_p2 <= vld_p1;
      if (s1_advance) begin
        data_p2 <= res_data;
        tag_p2  <= tag_p1;
        inv_p2  <= res_inv;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_tag   = tag_p2;
  assign out_inv   = inv_p2;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed-vector bench for fcmp_pipe (default 32-bit format); honours FCMP_NAN_EN.
module tb_fcmp_pipe;
  import fcmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_inv;

  int n_checks = 0;
  int n_fail   = 0;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_inv   (out_inv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Issue one op with out_ready high and capture its result; no checking here
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] d, output logic [4:0] t,
                        output logic inv, output int lat, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!out_valid) to = 1'b1;
    d = out_data; t = out_tag; inv = out_inv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_tag !== 5'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    n_checks++; if (out_inv !== 1'b0) begin n_fail++; $display("FAIL reset_out_inv got %b want 0", out_inv); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lt_basic();
    logic [31:0] d; logic [4:0] t; logic inv; int lat; bit to;
    run_op(FCMP_LT, 32'h3F800000, 32'h40000000, 5'h0A, d, t, inv, lat, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL lt_basic_timeout got %b want 0", to); end
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lt_1_2 got %h want 00000001", d); end
    n_checks++; if (t !== 5'h0A) begin n_fail++; $display("FAIL lt_1_2_tag got %h want 0a", t); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lt_latency got %0d want 2", lat); end
    n_checks++; if (inv !== 1'b0) begin n_fail++; $display("FAIL lt_1_2_inv got %b want 0", inv); end
    run_op(FCMP_LE, 32'h3F800000, 32'h3F800000, 5'h01, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL le_equal got %h want 00000001", d); end
    run_op(FCMP_EQ, 32'h3F800000, 32'h40000000, 5'h02, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL eq_1_2 got %h want 00000000", d); end
  endtask

  task automatic test_negative();
    logic [31:0] d; logic [4:0] t; logic inv; int lat; bit to;
    run_op(FCMP_LT, 32'hC0000000, 32'hBF800000, 5'h03, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lt_m2_m1 got %h want 00000001", d); end
    run_op(FCMP_LT, 32'hBF800000, 32'hC0000000, 5'h04, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lt_m1_m2 got %h want 00000000", d); end
    run_op(FCMP_MAX, 32'hC0000000, 32'hBF800000, 5'h05, d, t, inv, lat, to);
    n_checks++; if (d !== 32'hBF800000) begin n_fail++; $display("FAIL max_m2_m1 got %h want bf800000", d); end
    run_op(FCMP_MIN, 32'hC0000000, 32'hBF800000, 5'h06, d, t, inv, lat, to);
    n_checks++; if (d !== 32'hC0000000) begin n_fail++; $display("FAIL min_m2_m1 got %h want c0000000", d); end
    run_op(FCMP_LT, 32'hBF800000, 32'h3F800000, 5'h07, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lt_m1_p1 got %h want 00000001", d); end
  endtask

  task automatic test_signed_zero();
    logic [31:0] d; logic [4:0] t; logic inv; int lat; bit to;
    run_op(FCMP_EQ, 32'h80000000, 32'h00000000, 5'h08, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL eq_mz_pz got %h want 00000001", d); end
    run_op(FCMP_LT, 32'h80000000, 32'h00000000, 5'h09, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lt_mz_pz got %h want 00000000", d); end
    run_op(FCMP_LT, 32'h00000000, 32'h80000000, 5'h0B, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lt_pz_mz got %h want 00000000", d); end
    run_op(FCMP_LE, 32'h00000000, 32'h80000000, 5'h0C, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL le_pz_mz got %h want 00000001", d); end
    run_op(FCMP_MIN, 32'h80000000, 32'h00000000, 5'h0D, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h80000000) begin n_fail++; $display("FAIL min_mz_pz got %h want 80000000", d); end
    run_op(FCMP_MAX, 32'h80000000, 32'h00000000, 5'h0E, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h00000000) begin n_fail++; $display("FAIL max_mz_pz got %h want 00000000", d); end
  endtask

  task automatic test_illegal_op();
    logic [31:0] d; logic [4:0] t; logic inv; int lat; bit to;
    run_op(3'b101, 32'h3F800000, 32'h40000000, 5'h15, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL illegal_data got %h want 00000000", d); end
    n_checks++; if (inv !== 1'b1) begin n_fail++; $display("FAIL illegal_inv got %b want 1", inv); end
    n_checks++; if (t !== 5'h15) begin n_fail++; $display("FAIL illegal_tag got %h want 15", t); end
    run_op(3'b111, 32'h40000000, 32'h3F800000, 5'h16, d, t, inv, lat, to);
    n_checks++; if (inv !== 1'b1) begin n_fail++; $display("FAIL illegal7_inv got %b want 1", inv); end
  endtask

  task automatic test_nan();
    logic [31:0] d; logic [4:0] t; logic inv; int lat; bit to;
`ifdef FCMP_NAN_EN
    localparam logic        INV_E   = 1'b1;
    localparam logic [31:0] MAX_E   = 32'h3F800000;
    localparam logic [31:0] EQ_E    = 32'h0;
    localparam logic [31:0] BOTH_E  = 32'h7FC00000;
`else
    localparam logic        INV_E   = 1'b0;
    localparam logic [31:0] MAX_E   = 32'h7FC00001;
    localparam logic [31:0] EQ_E    = 32'h1;
    localparam logic [31:0] BOTH_E  = 32'hFFC00002;
`endif
    run_op(FCMP_LT, 32'h7FC00001, 32'h3F800000, 5'h11, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL nan_lt got %h want 00000000", d); end
    n_checks++; if (inv !== INV_E) begin n_fail++; $display("FAIL nan_lt_inv got %b want %b", inv, INV_E); end
    run_op(FCMP_MIN, 32'h7FC00001, 32'h3F800000, 5'h12, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h3F800000) begin n_fail++; $display("FAIL nan_min got %h want 3f800000", d); end
    run_op(FCMP_MAX, 32'h7FC00001, 32'h3F800000, 5'h13, d, t, inv, lat, to);
    n_checks++; if (d !== MAX_E) begin n_fail++; $display("FAIL nan_max got %h want %h", d, MAX_E); end
    run_op(FCMP_EQ, 32'h7FC00001, 32'h7FC00001, 5'h14, d, t, inv, lat, to);
    n_checks++; if (d !== EQ_E) begin n_fail++; $display("FAIL nan_eq_self got %h want %h", d, EQ_E); end
    run_op(FCMP_MIN, 32'h7FC00001, 32'hFFC00002, 5'h17, d, t, inv, lat, to);
    n_checks++; if (d !== BOTH_E) begin n_fail++; $display("FAIL nan_both_min got %h want %h", d, BOTH_E); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [8];
    logic [31:0] snap_d;
    logic [4:0]  snap_t;
    bit stalled_prev, saw_not_ready, acc;
    int idx, rx, extra;
    // MAX against b = 2^-124 (exp field 3): a wins only when its exponent field exceeds 3
    for (int i = 0; i < 8; i++) exp_d[i] = (i > 3) ? (32'(i) << 23) : 32'h01800000;
    idx = 0; rx = 0; stalled_prev = 1'b0; saw_not_ready = 1'b0;
    snap_d = '0; snap_t = '0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (idx < 8) begin
        in_valid = 1'b1; in_op = FCMP_MAX; in_a = 32'(idx) << 23; in_b = 32'h01800000; in_tag = 5'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) saw_not_ready = 1'b1;
      if (out_valid && stalled_prev) begin
        n_checks++;
        if (out_data !== snap_d || out_tag !== snap_t) begin
          n_fail++; $display("FAIL b2b_stable got %h/%h want %h/%h", out_data, out_tag, snap_d, snap_t);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_data !== exp_d[rx] || out_tag !== 5'(rx)) begin
          n_fail++; $display("FAIL b2b_result%0d got %h/%h want %h/%h", rx, out_data, out_tag, exp_d[rx], 5'(rx));
        end
        rx++;
      end
      stalled_prev = out_valid && !out_ready;
      snap_d = out_data; snap_t = out_tag;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    n_checks++; if (rx !== 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", rx); end
    n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL b2b_accepted got %0d want 8", idx); end
    n_checks++; if (saw_not_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop got %b want 1", saw_not_ready); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicate got %0d want 0", extra); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [4:0] t; logic inv; int lat; bit to; int stale;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = FCMP_LT; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'h1C;
    @(posedge clk);
    @(negedge clk);
    in_tag = 5'h1D;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_mid_stale got %0d want 0", stale); end
    run_op(FCMP_LT, 32'h40000000, 32'h3F800000, 5'h1E, d, t, inv, lat, to);
    n_checks++; if (d !== 32'h0 || t !== 5'h1E || lat !== 2) begin
      n_fail++; $display("FAIL rst_mid_fresh got %h/%h/%0d want 00000000/1e/2", d, t, lat);
    end
  endtask

  initial begin
    test_reset();
    test_lt_basic();
    test_negative();
    test_signed_zero();
    test_illegal_op();
    test_nan();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
